// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the VGA raster timing generator.
// Holds the line/frame phase encoding, 640x480@60 default timing,
// and the colour-bar table used when TEST_PATTERN_EN is defined.
package vga_timing_pkg;

  // Raster phase within a line (horizontal) or a frame (vertical).
  typedef enum logic [1:0] {
    ACT  = 2'd0,
    FP   = 2'd1,
    SYNC = 2'd2,
    BP   = 2'd3
  } phase_e;

  // 640x480@60 timing (25.175 MHz pixel rate).
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned NUM_BARS = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Colour of each vertical bar, left to right.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    unique case (idx)
      3'd0:    c = {8'hFF, 8'hFF, 8'hFF};  // white
      3'd1:    c = {8'hFF, 8'hFF, 8'h00};  // yellow
      3'd2:    c = {8'h00, 8'hFF, 8'hFF};  // cyan
      3'd3:    c = {8'h00, 8'hFF, 8'h00};  // green
      3'd4:    c = {8'hFF, 8'h00, 8'hFF};  // magenta
      3'd5:    c = {8'hFF, 8'h00, 8'h00};  // red
      3'd6:    c = {8'h00, 8'h00, 8'hFF};  // blue
      default: c = {8'h00, 8'h00, 8'h00};  // black
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACT/FP/SYNC/BP phase FSM.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   step         : advance one position this clock
//   cnt          : current position 0..TOTAL-1
//   phase        : current phase of the position in cnt
//   wrap         : combinational, high when this step leaves the last position
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int unsigned W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         step,
  output logic [W-1:0] cnt,
  output phase_e       phase,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d;
  phase_e       phase_q, phase_d;
  logic         last_c;

  assign last_c = (cnt_q == W'(TOTAL - 1));
  assign wrap   = step && last_c;
  assign cnt    = cnt_q;
  assign phase  = phase_q;

  // Next position and phase; the phase changes on the step that leaves
  // the last position of the current phase.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (step) begin
      cnt_d = last_c ? '0 : cnt_q + W'(1);
      unique case (phase_q)
        vga_timing_pkg::ACT:
          if (cnt_q == W'(ACTIVE - 1)) phase_d = vga_timing_pkg::FP;
        vga_timing_pkg::FP:
          if (cnt_q == W'(ACTIVE + FP - 1)) phase_d = vga_timing_pkg::SYNC;
        vga_timing_pkg::SYNC:
          if (cnt_q == W'(ACTIVE + FP + SYNC - 1)) phase_d = vga_timing_pkg::BP;
        vga_timing_pkg::BP:
          if (last_c) phase_d = vga_timing_pkg::ACT;
        default:
          phase_d = vga_timing_pkg::ACT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= vga_timing_pkg::ACT;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: HS, VS, BLANK_N, pixel coordinates and
// line/frame start pulses, all registered one pixel tick after the
// position they describe.
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset (priority over en)
//   en            : pixel tick; nothing advances without it
//   oVGA_HS/VS    : syncs, asserted level HS_POL / VS_POL
//   oVGA_BLANK_N  : 1 while in the visible area
//   oX, oY        : column / line of the position being output
//   oLine_start   : one-clock pulse with the first pixel of each visible line
//   oFrame_start  : one-clock pulse with pixel (0,0)
//   oR/oG/oB      : colour-bar test pattern, only when TEST_PATTERN_EN is defined
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW      = $clog2(H_TOTAL),
  localparam int unsigned YW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  output logic          oVGA_HS,
  output logic          oVGA_VS,
  output logic          oVGA_BLANK_N,
  output logic [XW-1:0] oX,
  output logic [YW-1:0] oY,
  output logic          oLine_start,
  output logic          oFrame_start
`ifdef TEST_PATTERN_EN
  ,
  output logic [7:0]    oR,
  output logic [7:0]    oG,
  output logic [7:0]    oB
`endif
);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  phase_e        h_phase, v_phase;
  logic          h_wrap, v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (en),
    .cnt     (h_cnt),
    .phase   (h_phase),
    .wrap    (h_wrap)
  );

  // h_wrap already includes en, so the line advances once per line end.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (h_wrap),
    .cnt     (v_cnt),
    .phase   (v_phase),
    .wrap    (v_wrap)
  );

  logic          blank_n_q, blank_n_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  // Set while the counters sit at (0,0) waiting for the tick that shows it.
  logic          frame_pend_q, frame_pend_d;

`ifdef TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACTIVE / NUM_BARS == 0) ? 1 : H_ACTIVE / NUM_BARS;

  rgb_t          rgb_q, rgb_d;
  logic [XW-1:0] bar_div_c;
  logic [2:0]    bar_sel_c;

  // Bar index, clamped so any remainder columns take the last bar.
  always_comb begin
    bar_div_c = h_cnt / XW'(BAR_W);
    bar_sel_c = (bar_div_c > XW'(NUM_BARS - 1)) ? 3'(NUM_BARS - 1) : 3'(bar_div_c);
  end
`endif

  // Output decode of the pre-advance position; holds when en is low,
  // except the pulses which always drop.
  always_comb begin
    blank_n_d     = blank_n_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_pend_d  = frame_pend_q;
`ifdef TEST_PATTERN_EN
    rgb_d         = rgb_q;
`endif
    if (en) begin
      blank_n_d     = (h_phase == ACT) && (v_phase == ACT);
      hs_d          = (h_phase == SYNC) ? HS_POL : ~HS_POL;
      vs_d          = (v_phase == SYNC) ? VS_POL : ~VS_POL;
      x_d           = h_cnt;
      y_d           = v_cnt;
      line_start_d  = (h_cnt == '0) && (v_phase == ACT);
      frame_start_d = frame_pend_q;
      frame_pend_d  = v_wrap;
`ifdef TEST_PATTERN_EN
      rgb_d         = ((h_phase == ACT) && (v_phase == ACT)) ? bar_colour(bar_sel_c) : '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blank_n_q     <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_pend_q  <= 1'b1;
`ifdef TEST_PATTERN_EN
      rgb_q         <= '0;
`endif
    end else begin
      blank_n_q     <= blank_n_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_pend_q  <= frame_pend_d;
`ifdef TEST_PATTERN_EN
      rgb_q         <= rgb_d;
`endif
    end
  end

  assign oVGA_HS      = hs_q;
  assign oVGA_VS      = vs_q;
  assign oVGA_BLANK_N = blank_n_q;
  assign oX           = x_q;
  assign oY           = y_q;
  assign oLine_start  = line_start_q;
  assign oFrame_start = frame_start_q;
`ifdef TEST_PATTERN_EN
  assign oR           = rgb_q.r;
  assign oG           = rgb_q.g;
  assign oB           = rgb_q.b;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two 8x6 instances (sync polarity low/high)
// and one 640x480 instance, checked every clock against a raster model,
// plus hand-computed expectations for the model itself.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, en_s, en_d;

  logic       hs_s, vs_s, bl_s, ls_s, fs_s;
  logic [2:0] x_s, y_s;
  logic       hs_p, vs_p, bl_p, ls_p, fs_p;
  logic [2:0] x_p, y_p;
  logic       hs_d, vs_d, bl_d, ls_d, fs_d;
  logic [9:0] x_d, y_d;
`ifdef TEST_PATTERN_EN
  logic [7:0] r_s, g_s, b_s, r_p, g_p, b_p, r_d, g_d, b_d;
`endif

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .en(en_s),
    .oVGA_HS(hs_s), .oVGA_VS(vs_s), .oVGA_BLANK_N(bl_s),
    .oX(x_s), .oY(y_s), .oLine_start(ls_s), .oFrame_start(fs_s)
`ifdef TEST_PATTERN_EN
    , .oR(r_s), .oG(g_s), .oB(b_s)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_p (
    .clk(clk), .reset_n(reset_n), .en(en_s),
    .oVGA_HS(hs_p), .oVGA_VS(vs_p), .oVGA_BLANK_N(bl_p),
    .oX(x_p), .oY(y_p), .oLine_start(ls_p), .oFrame_start(fs_p)
`ifdef TEST_PATTERN_EN
    , .oR(r_p), .oG(g_p), .oB(b_p)
`endif
  );

  vga_timing_gen dut_d (
    .clk(clk), .reset_n(reset_n), .en(en_d),
    .oVGA_HS(hs_d), .oVGA_VS(vs_d), .oVGA_BLANK_N(bl_d),
    .oX(x_d), .oY(y_d), .oLine_start(ls_d), .oFrame_start(fs_d)
`ifdef TEST_PATTERN_EN
    , .oR(r_d), .oG(g_d), .oB(b_d)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- raster model ----------------
  typedef struct {
    bit          blank, hs, vs, ls, fs;
    int          x, y;
    logic [23:0] rgb;
  } exp_t;

  function automatic logic [23:0] bar_rgb(input int x, input int ha);
    int bw;
    int idx;
    bw  = (ha / 8 < 1) ? 1 : ha / 8;
    idx = x / bw;
    if (idx > 7) idx = 7;
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Outputs for the n-th pixel tick since reset, from raster arithmetic.
  function automatic exp_t decode(input int n, input int ha, input int hf, input int hsw,
                                  input int hb, input int va, input int vf, input int vsw,
                                  input int vb, input bit hp, input bit vp);
    exp_t e;
    int ht, vt, p;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p  = n % (ht * vt);
    e.x     = p % ht;
    e.y     = p / ht;
    e.blank = (e.x < ha) && (e.y < va);
    e.hs    = (e.x >= ha + hf && e.x < ha + hf + hsw) ? hp : !hp;
    e.vs    = (e.y >= va + vf && e.y < va + vf + vsw) ? vp : !vp;
    e.ls    = (e.x == 0) && (e.y < va);
    e.fs    = (p == 0);
    e.rgb   = e.blank ? bar_rgb(e.x, ha) : 24'h0;
    return e;
  endfunction

  function automatic exp_t rst_exp(input bit hp, input bit vp);
    exp_t e;
    e.blank = 1'b0; e.hs = !hp; e.vs = !vp; e.ls = 1'b0; e.fs = 1'b0;
    e.x = 0; e.y = 0; e.rgb = 24'h0;
    return e;
  endfunction

  int   n_s, n_d;
  exp_t e_s, e_p, e_d;
  bit   model_valid = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      n_s = 0; n_d = 0;
      e_s = rst_exp(1'b0, 1'b0);
      e_p = rst_exp(1'b1, 1'b1);
      e_d = rst_exp(1'b0, 1'b0);
      model_valid = 1'b1;
    end else begin
      if (en_s) begin
        e_s = decode(n_s, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0);
        e_p = decode(n_s, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        n_s++;
      end else begin
        e_s.ls = 1'b0; e_s.fs = 1'b0; e_p.ls = 1'b0; e_p.fs = 1'b0;
      end
      if (en_d) begin
        e_d = decode(n_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        n_d++;
      end else begin
        e_d.ls = 1'b0; e_d.fs = 1'b0;
      end
    end
  end

  task automatic chk_exp(input string tag, input logic bl, input logic hs, input logic vs,
                         input logic [31:0] x, input logic [31:0] y, input logic ls,
                         input logic fs, input logic [23:0] rgb, input exp_t e);
    chk({tag, ".blank_n"}, 32'(bl), 32'(e.blank));
    chk({tag, ".hs"},      32'(hs), 32'(e.hs));
    chk({tag, ".vs"},      32'(vs), 32'(e.vs));
    chk({tag, ".x"},       x, e.x);
    chk({tag, ".y"},       y, e.y);
    chk({tag, ".line_st"}, 32'(ls), 32'(e.ls));
    chk({tag, ".frame_st"},32'(fs), 32'(e.fs));
`ifdef TEST_PATTERN_EN
    chk({tag, ".rgb"},     32'(rgb), 32'(e.rgb));
`else
    if (rgb !== 24'h0) chk({tag, ".rgb_tie"}, 32'(rgb), 32'h0);
`endif
  endtask

  // Per-clock comparison of every instance against the model.
  always @(posedge clk) begin
    #1;
    if (model_valid) begin
`ifdef TEST_PATTERN_EN
      chk_exp("s", bl_s, hs_s, vs_s, 32'(x_s), 32'(y_s), ls_s, fs_s, {r_s, g_s, b_s}, e_s);
      chk_exp("p", bl_p, hs_p, vs_p, 32'(x_p), 32'(y_p), ls_p, fs_p, {r_p, g_p, b_p}, e_p);
      chk_exp("d", bl_d, hs_d, vs_d, 32'(x_d), 32'(y_d), ls_d, fs_d, {r_d, g_d, b_d}, e_d);
`else
      chk_exp("s", bl_s, hs_s, vs_s, 32'(x_s), 32'(y_s), ls_s, fs_s, 24'h0, e_s);
      chk_exp("p", bl_p, hs_p, vs_p, 32'(x_p), 32'(y_p), ls_p, fs_p, 24'h0, e_p);
      chk_exp("d", bl_d, hs_d, vs_d, 32'(x_d), 32'(y_d), ls_d, fs_d, 24'h0, e_d);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input bit r, input bit es, input bit ed);
    @(negedge clk);
    reset_n = r; en_s = es; en_d = ed;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bl_line [6];
  logic [7:0] hs_line0;
  logic [7:0] vs_line4;
  logic [5:0] vs_x0;
  int         ls_cnt;
  int         fs_idx [$];
  int         t_fall [$];
  int         bl_cnt;
  bit         prev_hs;

  initial begin
    reset_n = 1'b0; en_s = 1'b0; en_d = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.blank_n", 32'(bl_s), 32'd0);
    chk("rst.hs",      32'(hs_s), 32'd1);
    chk("rst.vs",      32'(vs_s), 32'd1);
    chk("rst.x",       32'(x_s),  32'd0);
    chk("rst.y",       32'(y_s),  32'd0);
    chk("rst.frame_st",32'(fs_s), 32'd0);
    chk("rst.hs_pol1", 32'(hs_p), 32'd0);
    chk("rst.vs_pol1", 32'(vs_p), 32'd0);

    // Two full 8x6 frames with en every clock.
    ls_cnt = 0;
    for (int k = 0; k < 96; k++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (k < 48) begin
        bl_line[k / 8][7 - (k % 8)] = bl_s;
        if (k < 8) hs_line0[7 - k] = hs_s;
        if (k / 8 == 4) vs_line4[7 - (k % 8)] = vs_s;
        if (k % 8 == 0) vs_x0[5 - k / 8] = vs_s;
        if (ls_s) ls_cnt++;
      end
      if (k == 4) chk("pol1.hs_fp", 32'(hs_p), 32'd0);
      if (k == 5) chk("pol1.hs_sync", 32'(hs_p), 32'd1);
      if (fs_s) fs_idx.push_back(k);
    end
    for (int l = 0; l < 6; l++)
      chk($sformatf("blank_line%0d", l), 32'(bl_line[l]), (l < 3) ? 32'hF0 : 32'h00);
    chk("hs_line0", 32'(hs_line0), 32'b11111001);
    chk("vs_line4", 32'(vs_line4), 32'h00);
    chk("vs_lines", 32'(vs_x0), 32'b111101);
    chk("line_starts_per_frame", ls_cnt, 3);
    if (fs_idx.size() < 2) begin
      chk("frame_start_count", fs_idx.size(), 2);
    end else begin
      chk("first_frame_start", fs_idx[0], 0);
      chk("frame_period", fs_idx[1] - fs_idx[0], 48);
    end

    // Walk to (5,4): inside both syncs.
    for (int k = 0; k < 38; k++) cyc(1'b1, 1'b1, 1'b0);
    chk("pos.x", 32'(x_s), 32'd5);
    chk("pos.y", 32'(y_s), 32'd4);
    chk("pos.hs", 32'(hs_s), 32'd0);
    chk("pos.vs", 32'(vs_s), 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("freeze.x", 32'(x_s), 32'd5);
    chk("freeze.hs", 32'(hs_s), 32'd0);
    // Mid-frame reset, with en high to show reset wins.
    cyc(1'b0, 1'b1, 1'b0);
    chk("midrst.blank_n", 32'(bl_s), 32'd0);
    chk("midrst.x", 32'(x_s), 32'd0);
    chk("midrst.y", 32'(y_s), 32'd0);
    chk("midrst.hs", 32'(hs_s), 32'd1);
    chk("midrst.vs", 32'(vs_s), 32'd1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("release.frame_st", 32'(fs_s), 32'd1);
    chk("release.blank_n", 32'(bl_s), 32'd1);
    chk("release.x", 32'(x_s), 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("pulse_drop.frame_st", 32'(fs_s), 32'd0);
    chk("pulse_drop.line_st", 32'(ls_s), 32'd0);

    // 640x480 instance with en every second clock.
    bl_cnt = 0;
    prev_hs = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      cyc(1'b1, 1'b0, (c % 2) == 0);
      if (prev_hs && !hs_d) t_fall.push_back(c);
      prev_hs = hs_d;
      if (t_fall.size() == 1 && bl_d) bl_cnt++;
`ifdef TEST_PATTERN_EN
      if (c == 0)    chk("bar.x0",   32'({r_d, g_d, b_d}), 32'hFFFFFF);
      if (c == 160)  chk("bar.x80",  32'({r_d, g_d, b_d}), 32'hFFFF00);
      if (c == 1120) chk("bar.x560", 32'({r_d, g_d, b_d}), 32'h000000);
      if (c == 1300) chk("bar.blank",32'({r_d, g_d, b_d}), 32'h000000);
`endif
    end
    if (t_fall.size() < 2) begin
      chk("hs_fall_count", t_fall.size(), 2);
    end else begin
      chk("hs_period_clk", t_fall[1] - t_fall[0], 1600);
      chk("blank_high_clk", bl_cnt, 1280);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
